// File: rtl/ifetch_stage_pkg.sv
// Shared pipeline definitions: bubble/trap encodings, opcode field position,
// fetch-state encoding and IF/ID bundle widths.
package pipeline_defs;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR   = 32'h5400_0000;
    localparam logic [5:0]         TRAP_OPCODE = 6'h11;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    function automatic logic is_trap(input logic [INSTR_W-1:0] word);
        return word[OPC_HI:OPC_LO] == TRAP_OPCODE;
    endfunction

endpackage

// File: rtl/ifetch_stage_if.sv
// Fetch-stage bundle: imem address/data, hazard and redirect controls, IF/ID outputs.
interface ifetch_stage_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      initPC;
    logic [31:0]      instruction;
    logic             stall;
    logic             takeLeap;
    logic [31:0]      leapPC;
    logic [31:0]      iAddr;
    logic [31:0]      instr_1;
    logic [31:0]      incPC_1;
    logic             valid_1;
    logic             pc_enable;
    logic             halted;
    logic [CNT_W-1:0] fetchCount;

    modport master (
        input  initPC, instruction, stall, takeLeap, leapPC,
        output iAddr, instr_1, incPC_1, valid_1, pc_enable, halted, fetchCount
    );

    modport slave (
        output initPC, instruction, stall, takeLeap, leapPC,
        input  iAddr, instr_1, incPC_1, valid_1, pc_enable, halted, fetchCount
    );

endinterface

// File: rtl/ifetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise hold.
module if_id_reg
    import pipeline_defs::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    incpc_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    incpc_out,
    output logic               valid_out
);

    always_ff @(posedge clk) begin
        if (!rst || bubble) begin
            instr_out <= NOP_INSTR;
            incpc_out <= '0;
            valid_out <= 1'b0;
        end else if (load) begin
            instr_out <= instr_in;
            incpc_out <= incpc_in;
            valid_out <= 1'b1;
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem address, feeds IF/ID,
// and stops fetching on TRAP until redirected or reset.
module ifetch_stage
    import pipeline_defs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    ifetch_stage_if.master fetch
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_next_seq;
    logic [CNT_W-1:0]  fetch_cnt_q;
    logic              do_fetch;
    logic              hit_trap;
    logic              bubble;

    assign pc_next_seq = pc_q + 32'd4;
    assign hit_trap    = is_trap(fetch.instruction);
    assign bubble      = fetch.takeLeap || (state_q == HALTED);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (fetch.takeLeap)
            state_d = RUN;
        else if (state_q == RUN && !fetch.stall && hit_trap)
            state_d = HALTED;
    end

    always_comb begin
        do_fetch = (state_q == RUN) && !fetch.stall && !fetch.takeLeap;
        fetch.pc_enable = do_fetch;
        fetch.halted    = (state_q == HALTED);
    end

    // A fetched TRAP is latched but the PC parks on it.
    always_ff @(posedge clk) begin
        if (!rst)
            pc_q <= fetch.initPC;
        else if (fetch.takeLeap)
            pc_q <= {fetch.leapPC[31:2], 2'b00};
        else if (do_fetch && !hit_trap)
            pc_q <= pc_next_seq;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            fetch_cnt_q <= '0;
        else if (do_fetch)
            fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
    end

    assign fetch.iAddr      = pc_q;
    assign fetch.fetchCount = fetch_cnt_q;

    if_id_reg u_if_id (
        .clk       (clk),
        .rst       (rst),
        .load      (do_fetch),
        .bubble    (bubble),
        .instr_in  (fetch.instruction),
        .incpc_in  (pc_next_seq),
        .instr_out (fetch.instr_1),
        .incpc_out (fetch.incPC_1),
        .valid_out (fetch.valid_1)
    );

endmodule
